// File: rtl/byte_add_pkg.sv
// Shared types and constants for the byte-serial adder sequencer.
// Optional subtract mode is enabled by the ADD_SUB_EN macro.
package byte_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Byte index needs at least one bit even for a single-byte operand.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/byte_add_seq_if.sv
// Start/busy/done bundle between a client and the byte-serial adder.
// The sub member exists only when ADD_SUB_EN is defined.
interface byte_add_seq_if #(
    parameter int NBYTES = 4
);
    import byte_add_pkg::*;

    logic                       start;
    logic [BYTE_W*NBYTES-1:0]   A;
    logic [BYTE_W*NBYTES-1:0]   B;
    logic                       c;
`ifdef ADD_SUB_EN
    logic                       sub;
`endif
    logic                       busy;
    logic                       done;
    logic [BYTE_W*NBYTES-1:0]   O;
    logic                       o;

`ifdef ADD_SUB_EN
    modport master (
        output start, A, B, c, sub,
        input  busy, done, O, o
    );
    modport slave (
        input  start, A, B, c, sub,
        output busy, done, O, o
    );
`else
    modport master (
        output start, A, B, c,
        input  busy, done, O, o
    );
    modport slave (
        input  start, A, B, c,
        output busy, done, O, o
    );
`endif

endinterface

// File: rtl/byte_adder_core.sv
// Purely combinational 8-bit adder slice with carry in and out.
module byte_adder_core (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};

endmodule

// File: rtl/byte_add_seq.sv
// Adds two NBYTES-wide operands one byte per clock through a shared slice.
// ADD_SUB_EN adds a captured sub flag that turns the operation into A - B.
module byte_add_seq
    import byte_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    byte_add_seq_if.slave  bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_w(NBYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;
`ifdef ADD_SUB_EN
    logic               sub_q;
`endif

    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [BYTE_W-1:0]  s_d;
    logic               co_d;

    assign a_byte = a_q[{idx_q, 3'b000} +: BYTE_W];
`ifdef ADD_SUB_EN
    // Two's-complement subtract: invert B here, carry preset to 1 on start.
    assign b_byte = b_q[{idx_q, 3'b000} +: BYTE_W] ^ {BYTE_W{sub_q}};
`else
    assign b_byte = b_q[{idx_q, 3'b000} +: BYTE_W];
`endif

    byte_adder_core u_core (
        .a  (a_byte),
        .b  (b_byte),
        .ci (carry_q),
        .s  (s_d),
        .co (co_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        sum_q   <= '0;
                        idx_q   <= '0;
`ifdef ADD_SUB_EN
                        sub_q   <= bus.sub;
                        carry_q <= bus.sub | bus.c;
`else
                        carry_q <= bus.c;
`endif
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[{idx_q, 3'b000} +: BYTE_W] <= s_d;
                    carry_q <= co_d;
                    if (idx_q == LAST) begin
                        cout_q  <= co_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.O    = sum_q;
    assign bus.o    = cout_q;

endmodule

// File: tb/tb_byte_add_seq.sv
// Directed bench for byte_add_seq with NBYTES=4 and NBYTES=1 instances.
// Subtract vectors are included when ADD_SUB_EN is defined.
module tb_byte_add_seq;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_pass;

    byte_add_seq_if #(.NBYTES(4)) ifa ();
    byte_add_seq_if #(.NBYTES(1)) ifb ();

    byte_add_seq #(.NBYTES(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    byte_add_seq #(.NBYTES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic op4(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic ci,
                       input logic sb, input logic [31:0] eo,
                       input logic eco);
        int cyc;
        int bc;
        @(negedge clk);
        ifa.A = a;
        ifa.B = b;
        ifa.c = ci;
`ifdef ADD_SUB_EN
        ifa.sub = sb;
`else
        if (sb) $display("note: sub ignored in this build");
`endif
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        cyc = 1;
        bc = ifa.busy ? 1 : 0;
        while (!ifa.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ifa.busy) bc++;
        end
        chk({tag, ".lat"}, 64'(cyc), 64'd5);
        chk({tag, ".busycyc"}, 64'(bc), 64'd5);
        chk({tag, ".O"}, 64'(ifa.O), 64'(eo));
        chk({tag, ".o"}, 64'(ifa.o), 64'(eco));
        @(negedge clk);
        chk({tag, ".done_end"}, 64'(ifa.done), 64'd0);
        chk({tag, ".busy_end"}, 64'(ifa.busy), 64'd0);
    endtask

    task automatic op1(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic ci,
                       input logic [7:0] eo, input logic eco);
        int cyc;
        @(negedge clk);
        ifb.A = a;
        ifb.B = b;
        ifb.c = ci;
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        cyc = 1;
        while (!ifb.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".lat"}, 64'(cyc), 64'd2);
        chk({tag, ".O"}, 64'(ifb.O), 64'(eo));
        chk({tag, ".o"}, 64'(ifb.o), 64'(eco));
        @(negedge clk);
        chk({tag, ".busy_end"}, 64'(ifb.busy), 64'd0);
    endtask

    initial begin
        int ndone;
        int d1;
        int d2;
        logic [31:0] o1;
        logic [31:0] o2;
        logic c1;
        logic c2;

        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        ifa.start = 1'b0;
        ifa.A = '0;
        ifa.B = '0;
        ifa.c = 1'b0;
        ifb.start = 1'b0;
        ifb.A = '0;
        ifb.B = '0;
        ifb.c = 1'b0;
`ifdef ADD_SUB_EN
        ifa.sub = 1'b0;
        ifb.sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst.O", 64'(ifa.O), 64'd0);
        chk("rst.o", 64'(ifa.o), 64'd0);
        chk("rst.busy", 64'(ifa.busy), 64'd0);
        chk("rst.done", 64'(ifa.done), 64'd0);
        rst_n = 1'b1;

        op4("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
            32'h0000_0100, 1'b0);
        op4("t2a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
            32'h0000_0000, 1'b1);
        op4("t2b", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0,
            32'h0000_0001, 1'b0);
        op4("t2c", 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0,
            32'h9999_999A, 1'b0);

        // start held high; operands change mid-run
        @(negedge clk);
        ifa.A = 32'h0102_0304;
        ifa.B = 32'h1020_3040;
        ifa.c = 1'b0;
        ifa.start = 1'b1;
        ndone = 0;
        d1 = 0;
        d2 = 0;
        o1 = '0;
        o2 = '0;
        c1 = 1'b0;
        c2 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) begin
                ifa.A = 32'hFFFF_FFFF;
                ifa.B = 32'hFFFF_FFFF;
            end
            if (k == 6) chk("t3.busy_gap", 64'(ifa.busy), 64'd0);
            if (ifa.done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = k; o1 = ifa.O; c1 = ifa.o;
                end else begin
                    d2 = k; o2 = ifa.O; c2 = ifa.o;
                end
            end
            if (k == 7) ifa.start = 1'b0;
        end
        chk("t3.ndone", 64'(ndone), 64'd2);
        chk("t3.d1", 64'(d1), 64'd5);
        chk("t3.O1", 64'(o1), 64'h1122_3344);
        chk("t3.o1", 64'(c1), 64'd0);
        chk("t3.d2", 64'(d2), 64'd11);
        chk("t3.O2", 64'(o2), 64'hFFFF_FFFE);
        chk("t3.o2", 64'(c2), 64'd1);

        // reset during RUN at idx 2
        @(negedge clk);
        ifa.A = 32'h1234_5678;
        ifa.B = 32'h0000_0001;
        ifa.c = 1'b0;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4.pre_busy", 64'(ifa.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t4.O", 64'(ifa.O), 64'd0);
        chk("t4.o", 64'(ifa.o), 64'd0);
        chk("t4.busy", 64'(ifa.busy), 64'd0);
        chk("t4.done", 64'(ifa.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (ifa.done) ndone++;
        end
        chk("t4.nodone", 64'(ndone), 64'd0);
        op4("t4r", 32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0,
            32'h1234_5679, 1'b0);

        op1("t5a", 8'hAB, 8'h01, 1'b0, 8'hAC, 1'b0);
        op1("t5b", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        op1("t5c", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

`ifdef ADD_SUB_EN
        op4("t6a", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        op4("t6b", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
        op4("t6c", 32'd7, 32'd5, 1'b1, 1'b0, 32'h0000_000D, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
